// File: rtl/cpu_trace_capture_pkg.sv
// Shared constants for the trace capture block: parser state codes,
// checker format codes and the ASCII delimiters of a trace record.
package cpu_trace_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_TIME  = 3'd1;
    localparam state_t S_PC    = 3'd2;
    localparam state_t S_SEP   = 3'd3;
    localparam state_t S_REG   = 3'd4;
    localparam state_t S_ADDR  = 3'd5;
    localparam state_t S_ARROW = 3'd6;
    localparam state_t S_DATA  = 3'd7;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam logic [7:0] CH_CARET  = 8'h5E;  // '^'
    localparam logic [7:0] CH_AT     = 8'h40;  // '@'
    localparam logic [7:0] CH_COLON  = 8'h3A;  // ':'
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
    localparam logic [7:0] CH_STAR   = 8'h2A;  // '*'
    localparam logic [7:0] CH_LT     = 8'h3C;  // '<'
    localparam logic [7:0] CH_EQ     = 8'h3D;  // '='
    localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
    localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '

    // Decimal accumulate step for a 32-bit field: x*10 + d, truncated.
    function automatic logic [31:0] dec_step32(input logic [31:0] x, input logic [3:0] d);
        return (x << 3) + (x << 1) + {28'd0, d};
    endfunction

endpackage

// File: rtl/cpu_trace_capture_char_class.sv
// Combinational ASCII classifier: decimal digit, hex digit (either case)
// and the 4-bit value of the digit.
module trace_char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Classify one character and decode its digit value.
    always_comb begin
        is_dec = 1'b0;
        is_hex = 1'b0;
        nibble = 4'd0;
        if (char >= 8'h30 && char <= 8'h39) begin
            is_dec = 1'b1;
            is_hex = 1'b1;
            nibble = char[3:0];
        end else if ((char >= 8'h61 && char <= 8'h66) ||
                     (char >= 8'h41 && char <= 8'h46)) begin
            is_hex = 1'b1;
            nibble = char[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/cpu_trace_capture.sv
// Trace record capture: follows the ASCII trace stream alongside cpu_checker,
// accumulates the numeric fields of the current record and publishes them
// (with good/bad counters) when the checker reports a finished record.
module cpu_trace_capture
    import cpu_trace_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int TIME_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    input  logic [1:0]        format_type,
    input  logic [3:0]        error_code,
    output logic              rec_valid,
    output logic [1:0]        rec_type,
    output logic [TIME_W-1:0] rec_time,
    output logic [31:0]       rec_pc,
    output logic [31:0]       rec_target,
    output logic [31:0]       rec_data,
    output logic [3:0]        rec_error,
    output logic [CNT_W-1:0]  good_count,
    output logic [CNT_W-1:0]  bad_count
);

    logic              is_dec;
    logic              is_hex;
    logic [3:0]        nibble;

    state_t            state;
    logic [TIME_W-1:0] sh_time;
    logic [31:0]       sh_pc;
    logic [31:0]       sh_target;
    logic [31:0]       sh_data;
    logic              fmt_seen;
    logic              capture;

    trace_char_class u_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    // Parser: walks the record one character per edge and fills the shadow fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sh_time   <= '0;
            sh_pc     <= '0;
            sh_target <= '0;
            sh_data   <= '0;
        end else if (char == CH_CARET) begin
            state     <= S_TIME;
            sh_time   <= '0;
            sh_pc     <= '0;
            sh_target <= '0;
            sh_data   <= '0;
        end else if (char == CH_HASH) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_TIME: begin
                    if (is_dec)
                        sh_time <= (sh_time << 3) + (sh_time << 1) + TIME_W'(nibble);
                    else if (char == CH_AT)
                        state <= S_PC;
                    else
                        state <= S_IDLE;
                end
                S_PC: begin
                    if (is_hex)
                        sh_pc <= {sh_pc[27:0], nibble};
                    else if (char == CH_COLON)
                        state <= S_SEP;
                    else
                        state <= S_IDLE;
                end
                S_SEP: begin
                    if (char == CH_DOLLAR)
                        state <= S_REG;
                    else if (char == CH_STAR)
                        state <= S_ADDR;
                    else if (char != CH_SPACE)
                        state <= S_IDLE;
                end
                S_REG: begin
                    if (is_dec)
                        sh_target <= dec_step32(sh_target, nibble);
                    else if (char == CH_SPACE || char == CH_LT)
                        state <= S_ARROW;
                    else
                        state <= S_IDLE;
                end
                S_ADDR: begin
                    if (is_hex)
                        sh_target <= {sh_target[27:0], nibble};
                    else if (char == CH_SPACE || char == CH_LT)
                        state <= S_ARROW;
                    else
                        state <= S_IDLE;
                end
                S_ARROW: begin
                    if (is_hex) begin
                        sh_data <= {28'd0, nibble};
                        state   <= S_DATA;
                    end else if (char != CH_SPACE && char != CH_LT && char != CH_EQ) begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (is_hex)
                        sh_data <= {sh_data[27:0], nibble};
                    else if (char != CH_SPACE)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture only on the first edge of a nonzero format_type run.
    assign capture = (format_type != FMT_NONE) && !fmt_seen;

    // Publish the shadow fields and bump one saturating counter per record.
    always_ff @(posedge clk) begin
        if (reset) begin
            fmt_seen   <= 1'b0;
            rec_valid  <= 1'b0;
            rec_type   <= '0;
            rec_time   <= '0;
            rec_pc     <= '0;
            rec_target <= '0;
            rec_data   <= '0;
            rec_error  <= '0;
            good_count <= '0;
            bad_count  <= '0;
        end else begin
            fmt_seen  <= (format_type != FMT_NONE);
            rec_valid <= capture;
            if (capture) begin
                rec_type   <= format_type;
                rec_time   <= sh_time;
                rec_pc     <= sh_pc;
                rec_target <= sh_target;
                rec_data   <= sh_data;
                rec_error  <= error_code;
                if (error_code == 4'd0) begin
                    if (good_count != '1)
                        good_count <= good_count + CNT_W'(1);
                end else begin
                    if (bad_count != '1)
                        bad_count <= bad_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: the stimulus pushes the expected
// record for each accepted trace line, a monitor pops and compares on every
// rec_valid strobe. Counters are narrowed to 2 bits so saturation is reached.
module tb_cpu_trace_capture;

    localparam int CNT_W  = 2;
    localparam int TIME_W = 16;

    logic              clk;
    logic              reset;
    logic [7:0]        char;
    logic [1:0]        format_type;
    logic [3:0]        error_code;
    logic              rec_valid;
    logic [1:0]        rec_type;
    logic [TIME_W-1:0] rec_time;
    logic [31:0]       rec_pc;
    logic [31:0]       rec_target;
    logic [31:0]       rec_data;
    logic [3:0]        rec_error;
    logic [CNT_W-1:0]  good_count;
    logic [CNT_W-1:0]  bad_count;

    typedef struct {
        logic [1:0]  typ;
        logic [15:0] tm;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] data;
        logic [3:0]  err;
        logic [1:0]  good;
        logic [1:0]  bad;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    int         model_good = 0;
    int         model_bad  = 0;
    logic [1:0] pend_fmt   = 2'd0;
    logic [3:0] pend_err   = 4'd0;
    int         pend_hold  = 0;

    cpu_trace_capture #(.CNT_W(CNT_W), .TIME_W(TIME_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type),
        .error_code  (error_code),
        .rec_valid   (rec_valid),
        .rec_type    (rec_type),
        .rec_time    (rec_time),
        .rec_pc      (rec_pc),
        .rec_target  (rec_target),
        .rec_data    (rec_data),
        .rec_error   (rec_error),
        .good_count  (good_count),
        .bad_count   (bad_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One character per edge; a pending checker verdict rides along for pend_hold edges.
    task automatic send_char(input logic [7:0] c);
        if (pend_hold > 0) begin
            format_type = pend_fmt;
            error_code  = pend_err;
            pend_hold--;
        end else begin
            format_type = 2'd0;
            error_code  = 4'd0;
        end
        char = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    // Checker verdict for the record just sent, plus the expected capture.
    task automatic expect_rec(input logic [1:0] fmt, input logic [3:0] err,
                              input logic [15:0] tm, input logic [31:0] pc,
                              input logic [31:0] tgt, input logic [31:0] data,
                              input int hold);
        exp_t e;
        if (err == 4'd0) model_good = (model_good == 3) ? 3 : model_good + 1;
        else             model_bad  = (model_bad  == 3) ? 3 : model_bad  + 1;
        e.typ  = fmt;
        e.tm   = tm;
        e.pc   = pc;
        e.tgt  = tgt;
        e.data = data;
        e.err  = err;
        e.good = 2'(model_good);
        e.bad  = 2'(model_bad);
        q.push_back(e);
        pend_fmt  = fmt;
        pend_err  = err;
        pend_hold = hold;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(rec_valid), 32'd0);
        chk({tag, "_type"},  32'(rec_type), 32'd0);
        chk({tag, "_time"},  32'(rec_time), 32'd0);
        chk({tag, "_pc"},    rec_pc, 32'd0);
        chk({tag, "_tgt"},   rec_target, 32'd0);
        chk({tag, "_data"},  rec_data, 32'd0);
        chk({tag, "_err"},   32'(rec_error), 32'd0);
        chk({tag, "_good"},  32'(good_count), 32'd0);
        chk({tag, "_bad"},   32'(bad_count), 32'd0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rec_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rec_type",   32'(rec_type), 32'(e.typ));
                    chk("rec_time",   32'(rec_time), 32'(e.tm));
                    chk("rec_pc",     rec_pc, e.pc);
                    chk("rec_target", rec_target, e.tgt);
                    chk("rec_data",   rec_data, e.data);
                    chk("rec_error",  32'(rec_error), 32'(e.err));
                    chk("good_count", 32'(good_count), 32'(e.good));
                    chk("bad_count",  32'(bad_count), 32'(e.bad));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        char        = 8'h20;
        format_type = 2'd0;
        error_code  = 4'd0;
        send_str("   ");
        chk_all_zero("reset");
        reset = 1'b0;
        send_str("  ");

        // Register write with a semantic error.
        send_str("^242@000030f4: $32 <= 12345678#");
        expect_rec(2'd1, 4'd5, 16'd242, 32'h0000_30F4, 32'd32, 32'h1234_5678, 1);
        send_str("   ");

        // Memory write, verdict held for three edges: still one strobe.
        send_str("^338@00003130: *00000088 <= Ffffb528#");
        expect_rec(2'd2, 4'd0, 16'd338, 32'h0000_3130, 32'h0000_0088, 32'hFFFF_B528, 3);
        send_str("     ");

        // Rejected record: outputs and counters hold.
        send_str("^242@000030f4: $31 <=#");
        send_str("    ");
        chk("hold_valid", 32'(rec_valid), 32'd0);
        chk("hold_type",  32'(rec_type), 32'd2);
        chk("hold_time",  32'(rec_time), 32'd338);
        chk("hold_data",  rec_data, 32'hFFFF_B528);
        chk("hold_good",  32'(good_count), 32'd1);
        chk("hold_bad",   32'(bad_count), 32'd1);

        // Spaced data digits; time 70000 truncated to 16 bits.
        send_str("^70000@DEADbeef: $7 <=   12321 5 #");
        expect_rec(2'd1, 4'd0, 16'd4464, 32'hDEAD_BEEF, 32'd7, 32'h0012_3215, 1);
        send_str(" ");

        // Back-to-back: second '^' lands on the capture edge of the first.
        send_str("^1@00000010: *0000ABCD <= 00000001#");
        expect_rec(2'd2, 4'd0, 16'd1, 32'h0000_0010, 32'h0000_ABCD, 32'h0000_0001, 1);
        send_str("^65535@FFFFFFFF: $0 <= cafef00d#");
        expect_rec(2'd1, 4'd0, 16'd65535, 32'hFFFF_FFFF, 32'd0, 32'hCAFE_F00D, 1);
        send_str("   ");

        // Reset in the middle of the pc field.
        send_str("^99@00");
        reset = 1'b1;
        send_str("00");
        chk_all_zero("midreset");
        reset = 1'b0;
        model_good = 0;
        model_bad  = 0;
        send_str("3130: $5 <= 00000009#");
        send_str("  ");
        send_str("^5@00000100: $3 <= 0000000a#");
        expect_rec(2'd1, 4'd2, 16'd5, 32'h0000_0100, 32'd3, 32'h0000_000A, 1);
        send_str("      ");

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
